// File: rtl/stream_to_fifo_if_pkg.sv
// Purpose: shared constants and helpers for the stream-to-FIFO write adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_to_fifo_if_pkg;

  // Internal occupancy never exceeds two words (head + skid).
  localparam int LEVEL_W = 2;

  // Occupancy from the two entry-valid flags.
  function automatic logic [LEVEL_W-1:0] level_of(input logic head_vld, input logic skid_vld);
    return {1'b0, head_vld} + {1'b0, skid_vld};
  endfunction

endpackage

// File: rtl/stream_to_fifo_if.sv
// Purpose: valid/ready stream slave feeding a synchronous FIFO write port via a 2-entry skid buffer.
// Latency: word accepted at edge N is on fifo_data_o after N, written at edge N+1 if FIFO not full.
// Backpressure: registered ready; drops the cycle after the skid entry fills, never writes while full.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   stream_s_*        stream slave (data/valid in, registered ready out)
//   fifo_data_o       registered FIFO write data
//   fifo_wr_en_o      FIFO write enable (head valid and FIFO not full)
//   fifo_full_i       FIFO full flag, qualifies the write in the current cycle only
//   level_o           words held internally, 0..2
//   words_o           words written to the FIFO, wraps modulo 2^CW
module stream_to_fifo_if
  import stream_to_fifo_if_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  output logic [DW-1:0]      fifo_data_o,
  output logic               fifo_wr_en_o,
  input  logic               fifo_full_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic [CW-1:0]      words_o
);

  logic [DW-1:0] r_out_data;
  logic          r_out_valid;
  logic [DW-1:0] r_skid_data;
  logic          r_skid_valid;
  logic          r_ready;
  logic [CW-1:0] r_wcnt;

  logic w_accept;
  logic w_push;
  logic w_skid_valid_next;

  assign w_accept = stream_s_valid_i & r_ready;
  assign w_push   = r_out_valid & ~fifo_full_i;

  // The skid entry only fills when the head is stalled and a word arrives;
  // any write drains it (accept is impossible while it is occupied).
  always_comb begin
    w_skid_valid_next = r_skid_valid;
    if (w_push)
      w_skid_valid_next = 1'b0;
    else if (r_out_valid && w_accept)
      w_skid_valid_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_wcnt       <= '0;
    end else begin
      if (w_push) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          // Write and refill in the same cycle: head stays valid.
          r_out_data <= stream_s_data_i;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (!r_out_valid) begin
        if (w_accept) begin
          r_out_data  <= stream_s_data_i;
          r_out_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_skid_data  <= stream_s_data_i;
        r_skid_valid <= 1'b1;
      end
      // Ready is registered: it reflects whether the skid will be free next cycle.
      r_ready <= ~w_skid_valid_next;
      r_wcnt  <= r_wcnt + CW'(w_push);
    end
  end

  assign stream_s_ready_o = r_ready;
  assign fifo_data_o      = r_out_data;
  assign fifo_wr_en_o     = w_push;
  assign level_o          = level_of(r_out_valid, r_skid_valid);
  assign words_o          = r_wcnt;

endmodule

// File: tb/tb_stream_to_fifo_if.sv
module tb_stream_to_fifo_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        f_full = 1'b0;

  logic        s_ready;
  logic [7:0]  f_data;
  logic        f_wr;
  logic [1:0]  level;
  logic [31:0] words;

  logic        s_ready4;
  logic [7:0]  f_data4;
  logic        f_wr4;
  logic [1:0]  level4;
  logic [3:0]  words4;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  stream_to_fifo_if #(.DW(8), .CW(32)) dut (
    .clk(clk), .rst(rst),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid), .stream_s_ready_o(s_ready),
    .fifo_data_o(f_data), .fifo_wr_en_o(f_wr), .fifo_full_i(f_full),
    .level_o(level), .words_o(words)
  );

  // Narrow-counter instance sharing the same stimulus, used for wrap checks.
  stream_to_fifo_if #(.DW(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid), .stream_s_ready_o(s_ready4),
    .fifo_data_o(f_data4), .fifo_wr_en_o(f_wr4), .fifo_full_i(f_full),
    .level_o(level4), .words_o(words4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: words accepted on the stream must reach the FIFO in order.
  always @(posedge rst) exp_q.delete();

  always @(negedge clk) begin
    if (!rst) begin
      if (f_wr) begin
        chk("wr_while_full", {31'd0, f_full}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          chk("sb_data", {24'd0, f_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (level > 2'd2) chk("level_range", {30'd0, level}, 32'd2);
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       f;
    logic       rdy;
    logic       wr;
    logic       chkd;
    logic [7:0] dat;
    logic [1:0] lvl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int acc;
    int ncyc;
    logic [31:0] base;

    // Full-stall sequence: A0 in head, A1 in skid, A2 held off, then drain.
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd1};
    tbl[2] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
    tbl[3] = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
    tbl[4] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2'd2};
    tbl[5] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd0};

    // 1. Reset and idle
    #1;
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_wr", {31'd0, f_wr}, 32'd0);
    chk("rst_level", {30'd0, level}, 32'd0);
    chk("rst_words", words, 32'd0);
    cyc();
    cyc();
    chk("rst_ready_hold", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_edge", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("rel_ready_after_edge", {31'd0, s_ready}, 32'd1);

    // 2. Burst 0x01..0x10 at full rate
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 1);
      @(negedge clk);
      chk("burst_wr", {31'd0, f_wr}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("burst_data", {24'd0, f_data}, i);
      chk("burst_level", {30'd0, level}, (i > 0) ? 32'd1 : 32'd0);
      chk("burst_ready", {31'd0, s_ready}, 32'd1);
      cyc();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("burst_last_wr", {31'd0, f_wr}, 32'd1);
    chk("burst_last_data", {24'd0, f_data}, 32'h10);
    cyc();
    @(negedge clk);
    chk("burst_idle_level", {30'd0, level}, 32'd0);
    chk("burst_words", words, 32'd16);
    chk("wrap_words4_16", {28'd0, words4}, 32'd0);

    // 6. Two more words: narrow counter ends at 2
    cyc();
    s_valid = 1'b1; s_data = 8'h11; cyc();
    s_data = 8'h12; cyc();
    s_valid = 1'b0; cyc();
    cyc();
    chk("wrap_words_18", words, 32'd18);
    chk("wrap_words4_18", {28'd0, words4}, 32'd2);
    chk("wrap_level", {30'd0, level}, 32'd0);

    // 3. Full stall table
    foreach (tbl[k]) begin
      s_valid = tbl[k].v;
      s_data  = tbl[k].d;
      f_full  = tbl[k].f;
      @(negedge clk);
      chk($sformatf("stall_ready[%0d]", k), {31'd0, s_ready}, {31'd0, tbl[k].rdy});
      chk($sformatf("stall_wr[%0d]", k), {31'd0, f_wr}, {31'd0, tbl[k].wr});
      chk($sformatf("stall_level[%0d]", k), {30'd0, level}, {30'd0, tbl[k].lvl});
      if (tbl[k].chkd) chk($sformatf("stall_data[%0d]", k), {24'd0, f_data}, {24'd0, tbl[k].dat});
      cyc();
    end
    chk("stall_words", words, 32'd21);

    // 4. Random valid / full against the scoreboard
    base = words;
    acc = 0;
    ncyc = 0;
    while (acc < 10000 && ncyc < 80000) begin
      s_valid = ($urandom_range(0, 9) < 7);
      f_full  = ($urandom_range(0, 9) < 3);
      s_data  = 8'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      cyc();
      ncyc++;
    end
    chk("rand_accepts", acc, 32'd10000);
    s_valid = 1'b0;
    f_full  = 1'b0;
    repeat (4) cyc();
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_level", {30'd0, level}, 32'd0);
    chk("rand_words", words, base + 32'(acc));

    // 5. Async reset with two words held
    s_valid = 1'b1; s_data = 8'h66; f_full = 1'b1; cyc();
    s_data = 8'h77; cyc();
    s_valid = 1'b0;
    chk("pre_rst_level", {30'd0, level}, 32'd2);
    #1;
    f_full = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_wr", {31'd0, f_wr}, 32'd0);
    chk("arst_level", {30'd0, level}, 32'd0);
    chk("arst_words", words, 32'd0);
    chk("arst_data", {24'd0, f_data}, 32'd0);
    chk("arst_words4", {28'd0, words4}, 32'd0);
    cyc();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", {31'd0, s_ready}, 32'd0);
    cyc();
    chk("arst_ready_back", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1; s_data = 8'h55;
    @(negedge clk);
    chk("post_rst_no_wr", {31'd0, f_wr}, 32'd0);
    cyc();
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_wr", {31'd0, f_wr}, 32'd1);
    chk("post_rst_data", {24'd0, f_data}, 32'h55);
    cyc();
    chk("post_rst_words", words, 32'd1);
    chk("post_rst_level", {30'd0, level}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
